// File: rtl/fft_host_pkg.sv
// Shared types and default widths for the FFT stream host and the bridge bench.
package fft_host_pkg;

    localparam int HOST_DATA_WIDTH     = 32;
    localparam int HOST_SAMPLE_WIDTH   = 16;
    localparam int HOST_IDX_WIDTH      = 12;
    localparam int HOST_FIFO_DEPTH     = 16;
    localparam int HOST_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT_RES = 3'd2,
        RECV     = 3'd3,
        DONE     = 3'd4
    } host_fsm;

endpackage

// File: rtl/host_result_fifo.sv
// Synchronous first-word-fall-through result FIFO; DEPTH must be a power of two >= 2.
module host_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Push is gated by the registered full flag, so a same-cycle pop frees room only next cycle.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fft_stream_host.sv
// Host side of the FFT AXI bridge: streams one frame of samples out, collects the results.
// Optional result watchdog and o_TIMEOUT port enabled by defining FFT_HOST_TIMEOUT_EN.
module fft_stream_host
    import fft_host_pkg::*;
#(
    parameter int DATA_WIDTH     = HOST_DATA_WIDTH,
    parameter int SAMPLE_WIDTH   = HOST_SAMPLE_WIDTH,
    parameter int IDX_WIDTH      = HOST_IDX_WIDTH,
    parameter int FIFO_DEPTH     = HOST_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = HOST_TIMEOUT_CYCLES
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_START,
    input  logic [IDX_WIDTH-1:0]    i_FRAME_LEN,
    input  logic [SAMPLE_WIDTH-1:0] i_SAMPLE,
    input  logic                    i_SAMPLE_VALID,
    output logic                    o_SAMPLE_READY,
    output logic [SAMPLE_WIDTH-1:0] o_AWDATA,
    output logic                    o_AWVALID,
    input  logic                    i_AWREADY,
    output logic [IDX_WIDTH-1:0]    o_SAMPLES_NUMBER,
    input  logic [DATA_WIDTH-1:0]   i_ARDATA,
    input  logic                    i_ARVALID,
    output logic                    o_ARREADY,
    output logic [DATA_WIDTH-1:0]   o_RESULT,
    output logic                    o_RESULT_VALID,
    input  logic                    i_RESULT_READ,
    output logic                    o_BUSY,
    output logic                    o_DONE,
    output host_fsm                 o_STATE
`ifdef FFT_HOST_TIMEOUT_EN
    ,
    output logic                    o_TIMEOUT
`endif
);
    localparam int CNT_W  = IDX_WIDTH + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
        $error("fft_stream_host: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    host_fsm                 state_q, state_d;
    logic [IDX_WIDTH-1:0]    len_q, len_d;
    logic [CNT_W-1:0]        len_ext;
    logic [CNT_W-1:0]        acc_q, acc_d, sent_q, sent_d, recv_q, recv_d;
    logic [SAMPLE_WIDTH-1:0] awdata_q, awdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    sample_ready, sample_hs, aw_hs, ar_ready, ar_hs;
    logic                    fifo_full, fifo_empty;
    logic [FCNT_W-1:0]       fifo_count;
    logic [DATA_WIDTH-1:0]   fifo_head;
`ifdef FFT_HOST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]         wd_q, wd_d;
    logic                    timeout_q, timeout_d;
`endif

    assign len_ext = {1'b0, len_q};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        acc_d     = acc_q;
        sent_d    = sent_q;
        recv_d    = recv_q;
        awdata_d  = awdata_q;
        awvalid_d = awvalid_q;
`ifdef FFT_HOST_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = 1'b0;
`endif
        // 'accepted' limits intake; 'sent' tracks what actually left on AW.
        sample_ready = (state_q == SEND) && (acc_q < len_ext) && (!awvalid_q || i_AWREADY);
        sample_hs    = sample_ready && i_SAMPLE_VALID;
        aw_hs        = awvalid_q && i_AWREADY;
        ar_ready     = ((state_q == WAIT_RES) || (state_q == RECV)) && !fifo_full;
        ar_hs        = ar_ready && i_ARVALID;

        unique case (state_q)
            IDLE: begin
                if (i_START && (i_FRAME_LEN != '0)) begin
                    len_d   = i_FRAME_LEN;
                    acc_d   = '0;
                    sent_d  = '0;
                    recv_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (aw_hs) begin
                    sent_d    = sent_q + CNT_W'(1);
                    awvalid_d = 1'b0;
                    if (sent_d == len_ext) begin
                        state_d = WAIT_RES;
`ifdef FFT_HOST_TIMEOUT_EN
                        wd_d    = '0;
`endif
                    end
                end
                if (sample_hs) begin
                    acc_d     = acc_q + CNT_W'(1);
                    awdata_d  = i_SAMPLE;
                    awvalid_d = 1'b1;
                end
            end
            WAIT_RES, RECV: begin
                if (ar_hs) begin
                    recv_d  = recv_q + CNT_W'(1);
                    state_d = (recv_d == len_ext) ? DONE : RECV;
`ifdef FFT_HOST_TIMEOUT_EN
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            acc_q     <= '0;
            sent_q    <= '0;
            recv_q    <= '0;
            awdata_q  <= '0;
            awvalid_q <= 1'b0;
`ifdef FFT_HOST_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            acc_q     <= acc_d;
            sent_q    <= sent_d;
            recv_q    <= recv_d;
            awdata_q  <= awdata_d;
            awvalid_q <= awvalid_d;
`ifdef FFT_HOST_TIMEOUT_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    host_result_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (ar_hs),
        .push_data (i_ARDATA),
        .pop       (i_RESULT_READ),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The head is masked while empty so a flushed FIFO presents zero.
    assign o_RESULT         = fifo_empty ? '0 : fifo_head;
    assign o_RESULT_VALID   = (fifo_count != '0);
    assign o_SAMPLE_READY   = sample_ready;
    assign o_AWDATA         = awdata_q;
    assign o_AWVALID        = awvalid_q;
    assign o_SAMPLES_NUMBER = len_q;
    assign o_ARREADY        = ar_ready;
    assign o_BUSY           = (state_q != IDLE);
    assign o_DONE           = (state_q == DONE);
    assign o_STATE          = state_q;
`ifdef FFT_HOST_TIMEOUT_EN
    assign o_TIMEOUT        = timeout_q;
`endif

endmodule

// File: tb/tb_fft_stream_host.sv
// Scoreboard bench for fft_stream_host: AW samples and AR results are queued on
// handshake and compared when the DUT emits them.
module tb_fft_stream_host;
    import fft_host_pkg::*;

    localparam int DW = 32;
    localparam int SW = 16;
    localparam int IW = 12;
    localparam int FD = 4;
    localparam int TO = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_START;
    logic [IW-1:0] i_FRAME_LEN;
    logic [SW-1:0] i_SAMPLE;
    logic          i_SAMPLE_VALID;
    logic          o_SAMPLE_READY;
    logic [SW-1:0] o_AWDATA;
    logic          o_AWVALID;
    logic          i_AWREADY;
    logic [IW-1:0] o_SAMPLES_NUMBER;
    logic [DW-1:0] i_ARDATA;
    logic          i_ARVALID;
    logic          o_ARREADY;
    logic [DW-1:0] o_RESULT;
    logic          o_RESULT_VALID;
    logic          i_RESULT_READ;
    logic          o_BUSY;
    logic          o_DONE;
    host_fsm       o_STATE;
`ifdef FFT_HOST_TIMEOUT_EN
    logic          o_TIMEOUT;
`endif

    always #5 i_clk = ~i_clk;

    fft_stream_host #(
        .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .IDX_WIDTH(IW),
        .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_START(i_START), .i_FRAME_LEN(i_FRAME_LEN),
        .i_SAMPLE(i_SAMPLE), .i_SAMPLE_VALID(i_SAMPLE_VALID), .o_SAMPLE_READY(o_SAMPLE_READY),
        .o_AWDATA(o_AWDATA), .o_AWVALID(o_AWVALID), .i_AWREADY(i_AWREADY),
        .o_SAMPLES_NUMBER(o_SAMPLES_NUMBER), .i_ARDATA(i_ARDATA), .i_ARVALID(i_ARVALID),
        .o_ARREADY(o_ARREADY), .o_RESULT(o_RESULT), .o_RESULT_VALID(o_RESULT_VALID),
        .i_RESULT_READ(i_RESULT_READ), .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_STATE(o_STATE)
`ifdef FFT_HOST_TIMEOUT_EN
        , .o_TIMEOUT(o_TIMEOUT)
`endif
    );

    int checks   = 0;
    int failures = 0;
    logic [SW-1:0] aw_exp[$];
    logic [DW-1:0] res_exp[$];
    int  aw_hs_cnt = 0, ar_hs_cnt = 0, done_cnt = 0, frame_len = 0;
    int  cyc_now = 0, aw_first = 0, aw_last = 0;
    bit  want_wait = 0, want_done = 0, stall_pend = 0;
    logic [SW-1:0] stall_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"}, o_STATE, IDLE);
        chk({tag, "_busy"}, o_BUSY, 0);
        chk({tag, "_awvalid"}, o_AWVALID, 0);
        chk({tag, "_awdata"}, o_AWDATA, 0);
        chk({tag, "_samples_number"}, o_SAMPLES_NUMBER, 0);
        chk({tag, "_result_valid"}, o_RESULT_VALID, 0);
        chk({tag, "_result"}, o_RESULT, 0);
        chk({tag, "_arready"}, o_ARREADY, 0);
        chk({tag, "_sample_ready"}, o_SAMPLE_READY, 0);
        chk({tag, "_done"}, o_DONE, 0);
    endtask

    always @(posedge i_clk) cyc_now <= cyc_now + 1;

    // Monitor: inputs are stable at the falling edge, so valid&&ready here is the next edge's handshake.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (want_wait) begin
                chk("state_wait_res", o_STATE, WAIT_RES);
                chk("awvalid_drop", o_AWVALID, 0);
                want_wait = 0;
            end
            if (want_done) begin
                chk("done_pulse", o_DONE, 1);
                chk("state_done", o_STATE, DONE);
                want_done = 0;
            end
            if (o_DONE) done_cnt++;
            if (stall_pend) begin
                chk("aw_hold_valid", o_AWVALID, 1);
                chk("aw_hold_data", o_AWDATA, stall_data);
            end
            stall_pend = o_AWVALID && !i_AWREADY;
            stall_data = o_AWDATA;
            chk("result_valid", o_RESULT_VALID, res_exp.size() != 0);
            if (res_exp.size() == FD) chk("arready_full", o_ARREADY, 0);
            if (o_RESULT_VALID && i_RESULT_READ) begin
                if (res_exp.size() == 0) chk("result_extra", 1, 0);
                else chk("result", o_RESULT, res_exp.pop_front());
            end
            if (i_ARVALID && o_ARREADY) begin
                res_exp.push_back(i_ARDATA);
                ar_hs_cnt++;
                if (ar_hs_cnt == frame_len) want_done = 1;
            end
            if (o_AWVALID && i_AWREADY) begin
                if (aw_exp.size() == 0) chk("aw_extra", 1, 0);
                else chk("aw_data", o_AWDATA, aw_exp.pop_front());
                aw_hs_cnt++;
                if (aw_hs_cnt == 1) aw_first = cyc_now;
                aw_last = cyc_now;
                if (aw_hs_cnt == frame_len) want_wait = 1;
            end
            if (i_SAMPLE_VALID && o_SAMPLE_READY) aw_exp.push_back(i_SAMPLE);
        end
    end

    task automatic run_frame(input int len, input int s_base, input int r_base,
                             input bit aw_toggle, input int hold_read, input int budget);
        int s_idx = 0, r_idx = 0, cyc = 0;
        bit s_hs, r_hs;
        aw_hs_cnt = 0; ar_hs_cnt = 0; done_cnt = 0; frame_len = len;
        i_FRAME_LEN = IW'(len); i_START = 1'b1;
        i_SAMPLE = SW'(s_base); i_SAMPLE_VALID = 1'b1; i_AWREADY = 1'b1;
        i_ARDATA = DW'(r_base); i_ARVALID = 1'b1;
        i_RESULT_READ = (hold_read == 0);
        @(posedge i_clk); #1;
        i_START = 1'b0;
        chk("samples_number", o_SAMPLES_NUMBER, len);
        chk("busy", o_BUSY, 1);
        while (r_idx < len && cyc < budget) begin
            @(negedge i_clk);
            s_hs = i_SAMPLE_VALID && o_SAMPLE_READY;
            r_hs = i_ARVALID && o_ARREADY;
            @(posedge i_clk); #1;
            if (s_hs) begin
                s_idx++;
                i_SAMPLE = SW'(s_base + s_idx);
                if (s_idx == len) i_SAMPLE_VALID = 1'b0;
            end
            if (r_hs) begin
                r_idx++;
                i_ARDATA = DW'(r_base + 2 * r_idx);
                if (r_idx == len) i_ARVALID = 1'b0;
            end
            if (aw_toggle) i_AWREADY = ~i_AWREADY;
            cyc++;
            i_RESULT_READ = (cyc >= hold_read);
        end
        chk("ar_handshakes", r_idx, len);
        if (hold_read > budget) begin
            repeat (2) @(posedge i_clk);
            #1;
            chk("idle_fifo_held_state", o_STATE, IDLE);
            chk("idle_fifo_held_valid", o_RESULT_VALID, 1);
        end
        i_RESULT_READ = 1'b1;
        repeat (FD + 4) @(posedge i_clk);
        #1;
        chk("aw_handshakes", aw_hs_cnt, len);
        if (!aw_toggle) chk("aw_throughput", aw_last - aw_first, len - 1);
        chk("aw_queue_empty", aw_exp.size(), 0);
        chk("res_queue_empty", res_exp.size(), 0);
        chk("done_count", done_cnt, 1);
        chk("end_state", o_STATE, IDLE);
        chk("end_result_valid", o_RESULT_VALID, 0);
        i_RESULT_READ = 1'b0;
    endtask

    initial begin
        int s_idx, guard, n;
        bit s_hs;
        i_rst = 1'b1; i_START = 1'b0; i_FRAME_LEN = '0; i_SAMPLE = '0;
        i_SAMPLE_VALID = 1'b0; i_AWREADY = 1'b0; i_ARDATA = '0; i_ARVALID = 1'b0;
        i_RESULT_READ = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check_zero("reset");
        i_rst = 1'b0;

        i_FRAME_LEN = '0; i_START = 1'b1;
        @(posedge i_clk); #1;
        i_START = 1'b0;
        chk("zero_len_state", o_STATE, IDLE);
        chk("zero_len_busy", o_BUSY, 0);

        run_frame(4, 1, 50, 1'b0, 0, 100);
        run_frame(6, 10, 60, 1'b1, 0, 100);
        run_frame(10, 20, 2, 1'b0, 0, 100);
        run_frame(10, 100, 1000, 1'b0, 20, 200);

        // Abort a frame with reset after two accepted samples.
        aw_hs_cnt = 0; ar_hs_cnt = 0; done_cnt = 0; frame_len = 8;
        i_FRAME_LEN = IW'(8); i_START = 1'b1; i_SAMPLE = SW'(7);
        i_SAMPLE_VALID = 1'b1; i_AWREADY = 1'b1; i_ARVALID = 1'b0;
        @(posedge i_clk); #1;
        i_START = 1'b0;
        s_idx = 0; guard = 0;
        while (s_idx < 2 && guard < 20) begin
            @(negedge i_clk);
            s_hs = i_SAMPLE_VALID && o_SAMPLE_READY;
            @(posedge i_clk); #1;
            if (s_hs) begin
                s_idx++;
                i_SAMPLE = SW'(7 + s_idx);
            end
            guard++;
        end
        chk("mid_send_state", o_STATE, SEND);
        i_rst = 1'b1; i_SAMPLE_VALID = 1'b0;
        @(posedge i_clk); #1;
        check_zero("mid_reset");
        aw_exp.delete(); res_exp.delete();
        stall_pend = 0; want_wait = 0; want_done = 0;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("mid_reset_no_done", done_cnt, 0);
        chk("mid_reset_idle", o_STATE, IDLE);

        run_frame(3, 40, 300, 1'b0, 1000, 100);

`ifdef FFT_HOST_TIMEOUT_EN
        aw_hs_cnt = 0; ar_hs_cnt = 0; done_cnt = 0; frame_len = 2;
        i_FRAME_LEN = IW'(2); i_START = 1'b1; i_SAMPLE = SW'(5);
        i_SAMPLE_VALID = 1'b1; i_AWREADY = 1'b1; i_ARVALID = 1'b0;
        @(posedge i_clk); #1;
        i_START = 1'b0;
        guard = 0;
        do begin
            @(negedge i_clk);
            guard++;
        end while (o_STATE != WAIT_RES && guard < 20);
        i_SAMPLE_VALID = 1'b0;
        n = 0;
        while (!o_TIMEOUT && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        chk("timeout_latency", n, TO);
        chk("timeout_state", o_STATE, IDLE);
        chk("timeout_no_done", done_cnt, 0);
        @(negedge i_clk);
        chk("timeout_one_pulse", o_TIMEOUT, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_stream_host.md
# fft_stream_host

Host-side counterpart of the FFT AXI bridge: drives one frame of time-domain samples into the bridge's AW channel, then collects the same number of FFT results from the bridge's AR channel into a small result FIFO. It sits between the sample source (ADC or test pattern) and the bridge, and hands results to the consumer logic. One frame is processed per start pulse.

## Interface
- DATA_WIDTH, 32, result word width (bridge AR data)
- SAMPLE_WIDTH, 16, sample width (bridge AW data)
- IDX_WIDTH, 12, frame-length width
- FIFO_DEPTH, 16, result FIFO depth in entries; power of two, at least 2
- TIMEOUT_CYCLES, 4096, result watchdog limit (used only with FFT_HOST_TIMEOUT_EN)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_START  in  1  frame start pulse; sampled in IDLE only
- i_FRAME_LEN  in  IDX_WIDTH  samples per frame; latched on accepted start
- i_SAMPLE  in  SAMPLE_WIDTH  sample from source
- i_SAMPLE_VALID  in  1  source data valid
- o_SAMPLE_READY  out  1  sample accepted when valid and ready are both high
- o_AWDATA  out  SAMPLE_WIDTH  sample to bridge
- o_AWVALID  out  1  AW valid
- i_AWREADY  in  1  AW ready from bridge
- o_SAMPLES_NUMBER  out  IDX_WIDTH  latched frame length to bridge
- i_ARDATA  in  DATA_WIDTH  result from bridge
- i_ARVALID  in  1  AR valid from bridge
- o_ARREADY  out  1  AR ready; equals FIFO not full while in WAIT_RES or RECV, else 0
- o_RESULT  out  DATA_WIDTH  FIFO head (first-word fall-through)
- o_RESULT_VALID  out  1  FIFO not empty
- i_RESULT_READ  in  1  pops the head when o_RESULT_VALID is high
- o_BUSY  out  1  state is not IDLE
- o_DONE  out  1  one-cycle pulse in DONE
- o_TIMEOUT  out  1  one-cycle watchdog pulse (only with the macro)
- o_STATE  out  host_fsm  current state

## Operation
- States: IDLE, SEND, WAIT_RES, RECV, DONE.
- IDLE to SEND:
  - On i_START with i_FRAME_LEN not equal to 0: latch the length into o_SAMPLES_NUMBER and clear the sent and received counters.
  - A start with length 0 is ignored.
- SEND:
  - o_SAMPLE_READY = (accepted < len) and (not o_AWVALID or i_AWREADY).
  - An accepted sample loads the o_AWDATA/o_AWVALID register.
  - o_AWDATA is held stable while o_AWVALID is high and i_AWREADY is low.
  - sent increments on each AW handshake.
  - The handshake that makes sent equal to len moves the FSM to WAIT_RES; o_AWVALID drops in the same edge.
- WAIT_RES to RECV on the first AR handshake. If len is 1, that handshake goes straight to DONE.
- RECV:
  - Each AR handshake pushes i_ARDATA into the FIFO and increments received.
  - The handshake that makes received equal to len moves the FSM to DONE.
- DONE: o_DONE is 1 for one cycle, then IDLE.
- The FIFO drains independently of the FSM, including in IDLE. A new start is accepted even while the FIFO still holds data.
- Full FIFO: o_ARREADY is 0. A pop in that same cycle does not re-enable the push until the next cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged.
- Counters are IDX_WIDTH+1 bits, so no wrap occurs for the maximum length.

## Timing
- Reset (i_rst=1 at a clock edge): state IDLE; FIFO flushed; counters 0; all outputs 0 (o_SAMPLES_NUMBER=0, o_STATE=IDLE). This applies mid-frame as well: the frame is aborted with no DONE pulse.
- Sample accepted at edge t: o_AWVALID=1 with that data after edge t.
- Sustained throughput is 1 sample/cycle with i_AWREADY high.
- AR handshake at edge t into an empty FIFO: o_RESULT_VALID=1 after edge t.
- Last AR handshake at edge t: state DONE after t, with o_DONE high for the cycle after t.

## Configuration
- FFT_HOST_TIMEOUT_EN defined:
  - A watchdog counts cycles in WAIT_RES/RECV and clears on every AR handshake and on entry to WAIT_RES.
  - When the count reaches TIMEOUT_CYCLES, o_TIMEOUT pulses for one cycle and the FSM returns to IDLE with no o_DONE. FIFO contents are kept.
- FFT_HOST_TIMEOUT_EN undefined: no watchdog, the o_TIMEOUT port is absent, and the FSM waits indefinitely for results.

## Structure
- Package fft_host_pkg: the host_fsm enum (IDLE, SEND, WAIT_RES, RECV, DONE) and default width constants shared with the bridge bench.
- Sub-module host_result_fifo: synchronous FWFT FIFO with push, pop, full, empty and count.

## Test plan
- len=4, samples 1..4 back-to-back, i_AWREADY=1 -> o_AWDATA 1,2,3,4 on four consecutive cycles; o_SAMPLES_NUMBER=4; WAIT_RES after the 4th handshake.
- len=6, i_AWREADY toggling 1,0,1,0 -> o_AWDATA held during stalls, exactly 6 handshakes, values in order, no duplicates.
- len=10, i_ARDATA 2,4,...,20, i_RESULT_READ=1 -> o_RESULT 2..20 in order; a single o_DONE pulse one cycle after the 10th handshake.
- FIFO_DEPTH=4, len=10, i_RESULT_READ=0 -> o_ARREADY low after 4 handshakes; releasing the read completes all 10 transfers with no loss.
- i_rst asserted in SEND after 2 samples -> all outputs 0 on the next edge, state IDLE, FIFO empty; a following len=3 frame completes normally.
- FFT_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=16, no i_ARVALID -> o_TIMEOUT pulses 16 cycles after WAIT_RES entry; state IDLE; no o_DONE.
